// File: rtl/scan_chain_loader_pkg.sv
// Shared definitions for the scan chain loader: FSM state encoding and
// counter sizing helpers.
package scan_chain_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LOW,
    S_HIGH,
    S_DONE
  } scan_state_e;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int ctr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int words_per_load(input int chain_len, input int word_w);
    return chain_len / word_w;
  endfunction

endpackage

// File: rtl/scan_chain_loader_if.sv
// Config-word handshake and readback bus between a host and the scan chain loader.
interface scan_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] cfg_data;
  logic              cfg_last;
  logic              rb_valid;
  logic [WORD_W-1:0] rb_data;

  modport master (
    output cfg_valid, cfg_data, cfg_last,
    input  cfg_ready, rb_valid, rb_data
  );

  modport slave (
    input  cfg_valid, cfg_data, cfg_last,
    output cfg_ready, rb_valid, rb_data
  );
endinterface

// File: rtl/scan_chain_loader_phase_ctr.sv
// Times one shift_clk phase: counts DIV clk cycles while run is high and
// flags the final cycle of the phase.
module scan_chain_loader_phase_ctr
  import scan_chain_loader_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic last
);
  localparam int CW = ctr_w(DIV);

  logic [CW-1:0] cnt;

  assign last = run && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!run || last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/scan_chain_loader.sv
// Serializes config words LSB-first into a scan chain with a flop-generated
// shift_clk, capturing the chain tail into readback words as it goes.
module scan_chain_loader
  import scan_chain_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int DIV       = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  scan_chain_loader_if.slave  cfg,
  output logic                shift_clk,
  output logic                shift_i,
  input  logic                shift_o,
  output logic                busy,
  output logic                done,
  output logic                err
);
  localparam int WORDS   = words_per_load(CHAIN_LEN, WORD_W);
  localparam int BIT_W   = ctr_w(WORD_W);
  localparam int WORD_CW = ctr_w(WORDS);

  scan_state_e        state;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WORD_CW-1:0] word_cnt;
  logic [WORD_W-1:0]  data_sr;
  logic [WORD_W-1:0]  data_nxt;
  logic [WORD_W-1:0]  rb_sr;
  logic               phase_run;
  logic               phase_last;
  logic               take;
  logic               low_end;
  logic               high_step;
  logic               last_bit;
  logic               final_word;

  assign phase_run  = (state == S_LOW) || (state == S_HIGH);
  assign take       = ((state == S_IDLE) || (state == S_WAIT)) && cfg.cfg_valid;
  assign low_end    = (state == S_LOW) && phase_last;
  assign last_bit   = (bit_cnt == BIT_W'(WORD_W - 1));
  assign high_step  = (state == S_HIGH) && phase_last && !last_bit;
  assign final_word = (word_cnt == WORD_CW'(WORDS - 1));
  assign data_nxt   = data_sr >> 1;

  scan_chain_loader_phase_ctr #(.DIV(DIV)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (phase_run),
    .last  (phase_last)
  );

  // Data shift registers carry no reset; the FSM decides when they are meaningful.
  always_ff @(posedge clk) begin
    if (take) begin
      data_sr <= cfg.cfg_data;
    end else if (high_step) begin
      data_sr <= data_nxt;
    end
    if (low_end) begin
      rb_sr <= {shift_o, rb_sr[WORD_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      cfg.cfg_ready <= 1'b1;
      cfg.rb_valid  <= 1'b0;
      cfg.rb_data   <= '0;
      shift_clk     <= 1'b0;
      shift_i       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      cfg.rb_valid <= 1'b0;
      done         <= 1'b0;
      case (state)
        S_IDLE, S_WAIT: begin
          if (take) begin
            shift_i       <= cfg.cfg_data[0];
            bit_cnt       <= '0;
            cfg.cfg_ready <= 1'b0;
            busy          <= 1'b1;
            state         <= S_LOW;
            // Framing is flagged but never shortens or extends the load.
            if (cfg.cfg_last != final_word) begin
              err <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (phase_last) begin
            shift_clk <= 1'b1;
            state     <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (phase_last) begin
            shift_clk <= 1'b0;
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 1'b1;
              shift_i <= data_nxt[0];
              state   <= S_LOW;
            end else begin
              cfg.rb_valid <= 1'b1;
              cfg.rb_data  <= rb_sr;
              if (final_word) begin
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                word_cnt      <= word_cnt + 1'b1;
                cfg.cfg_ready <= 1'b1;
                state         <= S_WAIT;
              end
            end
          end
        end
        S_DONE: begin
          word_cnt      <= '0;
          busy          <= 1'b0;
          cfg.cfg_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader with a 16-flop chain model on shift_clk.
module tb_scan_chain_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic shift_clk, shift_i, shift_o, busy, done, err;

  scan_chain_loader_if #(.WORD_W(8)) bus ();

  scan_chain_loader #(.CHAIN_LEN(16), .WORD_W(8), .DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg       (bus),
    .shift_clk (shift_clk),
    .shift_i   (shift_i),
    .shift_o   (shift_o),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Chain model and event monitor, sampled in the clk domain.
  logic [15:0] chain;
  logic [15:0] pre_val = 16'h0;
  logic        clr_req = 1'b0;
  logic        prev_sclk = 1'b0;
  int          edge_cnt = 0;
  int          rb_cnt = 0;
  int          done_cnt = 0;
  logic        edge_bits [16];
  logic [7:0]  rb_log [4];

  assign shift_o = chain[0];

  always @(posedge clk) begin
    prev_sclk <= shift_clk;
    if (clr_req) begin
      chain    <= pre_val;
      edge_cnt <= 0;
      rb_cnt   <= 0;
      done_cnt <= 0;
    end else begin
      if (shift_clk && !prev_sclk) begin
        chain <= {shift_i, chain[15:1]};
        if (edge_cnt < 16) edge_bits[edge_cnt] <= shift_i;
        edge_cnt <= edge_cnt + 1;
      end
      if (bus.rb_valid) begin
        if (rb_cnt < 4) rb_log[rb_cnt] <= bus.rb_data;
        rb_cnt <= rb_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  w0, w1;
    logic        l0, l1;
    logic [15:0] pre;
    logic [15:0] exp_chain;
    logic [7:0]  rb0, rb1;
    logic        exp_err;
    int          gap;
  } vec_t;

  vec_t vecs [5];

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic clear_model(input logic [15:0] p);
    @(negedge clk);
    pre_val = p;
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int t;
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = d;
    bus.cfg_last  = l;
    t = 0;
    while (!bus.cfg_ready && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("send_ready", {31'b0, bus.cfg_ready}, 32'd1);
    @(posedge clk);
    #1 bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("load_end", {31'b0, busy}, 32'd0);
  endtask

  task automatic run_vec(input int i);
    int t;
    do_reset();
    clear_model(vecs[i].pre);
    send(vecs[i].w0, vecs[i].l0);
    if (vecs[i].gap > 0) begin
      t = 0;
      @(negedge clk);
      while (!bus.cfg_ready && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("gap_ready", {31'b0, bus.cfg_ready}, 32'd1);
      for (int g = 0; g < vecs[i].gap; g++) begin
        check("gap_sclk", {31'b0, shift_clk}, 32'd0);
        check("gap_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
      end
    end
    send(vecs[i].w1, vecs[i].l1);
    wait_idle();
    check("edges", edge_cnt, 32'd16);
    check("chain", {16'b0, chain}, {16'b0, vecs[i].exp_chain});
    check("rb_count", rb_cnt, 32'd2);
    check("rb_word0", {24'b0, rb_log[0]}, {24'b0, vecs[i].rb0});
    check("rb_word1", {24'b0, rb_log[1]}, {24'b0, vecs[i].rb1});
    check("done_count", done_cnt, 32'd1);
    check("err", {31'b0, err}, {31'b0, vecs[i].exp_err});
    check("ready_after", {31'b0, bus.cfg_ready}, 32'd1);
  endtask

  initial begin
    int t;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'h00;
    bus.cfg_last  = 1'b0;

    //               w0     w1     l0    l1    pre       chain     rb0    rb1    err   gap
    vecs[0] = '{8'hA5, 8'h3C, 1'b0, 1'b1, 16'h0000, 16'h3CA5, 8'h00, 8'h00, 1'b0, 0};
    vecs[1] = '{8'h12, 8'h34, 1'b0, 1'b1, 16'hBEEF, 16'h3412, 8'hEF, 8'hBE, 1'b0, 0};
    vecs[2] = '{8'hFF, 8'h00, 1'b0, 1'b1, 16'h1234, 16'h00FF, 8'h34, 8'h12, 1'b0, 10};
    vecs[3] = '{8'h5A, 8'hC3, 1'b1, 1'b1, 16'h0000, 16'hC35A, 8'h00, 8'h00, 1'b1, 0};
    vecs[4] = '{8'h01, 8'h80, 1'b0, 1'b0, 16'hFFFF, 16'h8001, 8'hFF, 8'hFF, 1'b1, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, bus.cfg_ready}, 32'd1);
    check("rst_sclk", {31'b0, shift_clk}, 32'd0);
    check("rst_shift_i", {31'b0, shift_i}, 32'd0);
    check("rst_rb_valid", {31'b0, bus.rb_valid}, 32'd0);
    check("rst_rb_data", {24'b0, bus.rb_data}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_vec(i);
      if (i == 0) begin
        check("first_bit0", {31'b0, edge_bits[0]}, 32'd1);
        check("first_bit1", {31'b0, edge_bits[1]}, 32'd0);
        check("first_bit2", {31'b0, edge_bits[2]}, 32'd1);
        check("first_bit3", {31'b0, edge_bits[3]}, 32'd0);
      end
    end

    // Reset in the middle of a load, then a clean reload.
    do_reset();
    clear_model(16'h0000);
    send(8'hA5, 1'b0);
    t = 0;
    while (edge_cnt < 5 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("mid_edges", edge_cnt, 32'd5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_sclk", {31'b0, shift_clk}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_ready", {31'b0, bus.cfg_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("mid_rst_no_rb", rb_cnt, 32'd0);
    check("mid_rst_no_done", done_cnt, 32'd0);
    check("mid_rst_idle_sclk", {31'b0, shift_clk}, 32'd0);
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
